// File: rtl/f1_start_ctrl.sv
// F1 race-start light sequencer: lights ramp one per prescaler tick, random hold,
// lights out, then reaction-time measurement with jump-start detection.
module f1_start_ctrl #(
  parameter int WIDTH      = 16,
  parameter int LFSR_WIDTH = 7,
  parameter int RT_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    N,
  input  logic                trigger,
  input  logic                button,
  output logic [7:0]          data_out,
  output logic                busy,
  output logic [RT_WIDTH-1:0] rt,
  output logic                rt_valid,
  output logic                jump_start
);

  // state  | meaning
  // IDLE   | waiting for first trigger after reset
  // LIGHTS | lights turning on one per tick
  // HOLD   | all lights on, counting down random hold ticks
  // GO     | lights out, counting reaction cycles
  // DONE   | result (or jump start) held until next trigger
  typedef enum logic [2:0] {
    S_IDLE,
    S_LIGHTS,
    S_HOLD,
    S_GO,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            data_q, data_d;
  logic                  busy_q, busy_d;
  logic [RT_WIDTH-1:0]   rt_q, rt_d;
  logic                  rt_valid_q, rt_valid_d;
  logic                  jump_q, jump_d;
  logic [WIDTH-1:0]      pre_q, pre_d;
  logic [LFSR_WIDTH-1:0] hold_q, hold_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [RT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                  tick;

  assign tick = (pre_q == '0);

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    rt_d       = rt_q;
    rt_valid_d = rt_valid_q;
    jump_d     = jump_q;
    pre_d      = pre_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    // x^W + x^(W-1) + 1; maximal length for the default width of 7
    lfsr_d     = {lfsr_q[LFSR_WIDTH-2:0], lfsr_q[LFSR_WIDTH-1] ^ lfsr_q[LFSR_WIDTH-2]};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (trigger) begin
          data_d     = 8'h01;
          pre_d      = N;
          jump_d     = 1'b0;
          rt_valid_d = 1'b0;
          state_d    = S_LIGHTS;
        end
      end

      S_LIGHTS: begin
        if (button) begin
          data_d     = 8'h00;
          jump_d     = 1'b1;
          rt_valid_d = 1'b0;
          state_d    = S_DONE;
        end else begin
          pre_d = tick ? N : pre_q - WIDTH'(1);
          if (tick) begin
            data_d = {data_q[6:0], 1'b1};
            // the tick that lights the last lamp also arms the hold,
            // so hold ticks are counted from the moment all lights are on
            if (data_q[6]) begin
              hold_d  = lfsr_q;
              state_d = S_HOLD;
            end
          end
        end
      end

      S_HOLD: begin
        if (button) begin
          data_d     = 8'h00;
          jump_d     = 1'b1;
          rt_valid_d = 1'b0;
          state_d    = S_DONE;
        end else begin
          pre_d = tick ? N : pre_q - WIDTH'(1);
          if (tick) begin
            hold_d = hold_q - LFSR_WIDTH'(1);
            if (hold_q == LFSR_WIDTH'(1)) begin
              data_d  = 8'h00;
              cnt_d   = '0;
              state_d = S_GO;
            end
          end
        end
      end

      S_GO: begin
        if (button) begin
          rt_d       = cnt_q;
          rt_valid_d = 1'b1;
          state_d    = S_DONE;
        end else if (cnt_q != {RT_WIDTH{1'b1}}) begin
          cnt_d = cnt_q + RT_WIDTH'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_LIGHTS) || (state_d == S_HOLD) || (state_d == S_GO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      data_q     <= 8'h00;
      busy_q     <= 1'b0;
      rt_q       <= '0;
      rt_valid_q <= 1'b0;
      jump_q     <= 1'b0;
      pre_q      <= '0;
      hold_q     <= '0;
      lfsr_q     <= LFSR_WIDTH'(1);
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      rt_q       <= rt_d;
      rt_valid_q <= rt_valid_d;
      jump_q     <= jump_d;
      pre_q      <= pre_d;
      hold_q     <= hold_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign data_out   = data_q;
  assign busy       = busy_q;
  assign rt         = rt_q;
  assign rt_valid   = rt_valid_q;
  assign jump_start = jump_q;

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Scoreboard bench for f1_start_ctrl: default instance plus a 4-bit reaction
// counter instance for the saturation case.
module tb_f1_start_ctrl;

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   h     = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, trigger, button;
  logic [15:0] n_val;
  logic [7:0]  data_out;
  logic        busy, rt_valid, jump_start;
  logic [15:0] rt;

  logic        rst2, trig2, btn2;
  logic [15:0] n2;
  logic [7:0]  data2;
  logic        busy2, rtv2, js2;
  logic [3:0]  rt2;

  f1_start_ctrl #(.WIDTH(16), .LFSR_WIDTH(7), .RT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .N(n_val), .trigger(trigger), .button(button),
    .data_out(data_out), .busy(busy), .rt(rt), .rt_valid(rt_valid),
    .jump_start(jump_start)
  );

  f1_start_ctrl #(.WIDTH(16), .LFSR_WIDTH(7), .RT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst2), .N(n2), .trigger(trig2), .button(btn2),
    .data_out(data2), .busy(busy2), .rt(rt2), .rt_valid(rtv2),
    .jump_start(js2)
  );

  // reference LFSR x^7+x^6+1, reset to 1, free running
  logic [6:0] m_lfsr;
  logic [6:0] lfsr_before;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 7'd1;
    else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  end

  task automatic step();
    lfsr_before = m_lfsr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; trigger = 1'b0; button = 1'b0; n_val = 16'd3;
    rst2 = 1'b1; trig2 = 1'b0; btn2 = 1'b0; n2 = 16'd0;
    step(); step();
    rst = 1'b0;
    n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data got %0h exp 0", data_out); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b exp 0", busy); end
    n_vec++; if (rt !== 16'd0) begin n_err++; $display("FAIL reset_rt got %0d exp 0", rt); end
    n_vec++; if (rt_valid !== 1'b0) begin n_err++; $display("FAIL reset_rt_valid got %0b exp 0", rt_valid); end
    n_vec++; if (jump_start !== 1'b0) begin n_err++; $display("FAIL reset_jump got %0b exp 0", jump_start); end
  endtask

  task automatic test_lights();
    exp_t e;
    bit   busy_bad = 0;
    sb.push_back('{cyc: 1,  val: 16'h01});
    sb.push_back('{cyc: 5,  val: 16'h03});
    sb.push_back('{cyc: 29, val: 16'hFF});
    cyc = 0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    while (1) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_vec++;
        if (data_out !== e.val[7:0]) begin
          n_err++; $display("FAIL lights_c%0d got %0h exp %0h", cyc, data_out, e.val[7:0]);
        end
      end
      if (busy !== 1'b1) busy_bad = 1;
      if (cyc == 29) break;
      step();
    end
    h = int'(lfsr_before);
    n_vec++; if (busy_bad) begin n_err++; $display("FAIL lights_busy got 0 exp 1"); end
  endtask

  task automatic test_hold();
    exp_t e;
    bit   busy_bad = 0;
    int   lim = cyc + 4 * 127 + 20;
    sb.push_back('{cyc: 29 + 4 * h, val: 16'h00});
    while (data_out !== 8'h00 && cyc < lim) begin
      if (busy !== 1'b1) busy_bad = 1;
      step();
    end
    e = sb.pop_front();
    n_vec++;
    if (cyc != e.cyc || data_out !== 8'h00) begin
      n_err++; $display("FAIL hold_fall got cycle %0d exp cycle %0d (H=%0d)", cyc, e.cyc, h);
    end
    n_vec++; if (busy_bad || busy !== 1'b1) begin n_err++; $display("FAIL hold_busy got %0b exp 1", busy); end
  endtask

  task automatic test_reaction();
    exp_t e;
    repeat (10) step();
    button = 1'b1;
    sb.push_back('{cyc: cyc + 1, val: 16'd10});
    step();
    button = 1'b0;
    e = sb.pop_front();
    n_vec++; if (rt !== e.val) begin n_err++; $display("FAIL react_rt got %0d exp %0d", rt, e.val); end
    n_vec++; if (rt_valid !== 1'b1) begin n_err++; $display("FAIL react_valid got %0b exp 1", rt_valid); end
    n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL react_data got %0h exp 0", data_out); end
    n_vec++; if (jump_start !== 1'b0) begin n_err++; $display("FAIL react_jump got %0b exp 0", jump_start); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL react_busy got %0b exp 0", busy); end
  endtask

  task automatic test_jump_start();
    cyc = 0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    n_vec++; if (data_out !== 8'h01) begin n_err++; $display("FAIL restart_data got %0h exp 1", data_out); end
    n_vec++; if (rt_valid !== 1'b0) begin n_err++; $display("FAIL restart_valid got %0b exp 0", rt_valid); end
    while (data_out !== 8'h07 && cyc < 40) step();
    n_vec++; if (cyc != 9) begin n_err++; $display("FAIL jump_reach07 got cycle %0d exp 9", cyc); end
    button = 1'b1;
    step();
    n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL jump_data got %0h exp 0", data_out); end
    n_vec++; if (jump_start !== 1'b1) begin n_err++; $display("FAIL jump_flag got %0b exp 1", jump_start); end
    n_vec++; if (rt_valid !== 1'b0) begin n_err++; $display("FAIL jump_valid got %0b exp 0", rt_valid); end
    n_vec++; if (rt !== 16'd10) begin n_err++; $display("FAIL jump_rt_held got %0d exp 10", rt); end
    repeat (3) step();
    button = 1'b0;
    n_vec++; if (busy !== 1'b0 || data_out !== 8'h00) begin
      n_err++; $display("FAIL done_button busy %0b data %0h exp 0 0", busy, data_out);
    end
  endtask

  task automatic test_trigger_held_and_reset();
    exp_t e;
    sb.push_back('{cyc: 1, val: 16'h01});
    sb.push_back('{cyc: 5, val: 16'h03});
    sb.push_back('{cyc: 9, val: 16'h07});
    cyc = 0;
    trigger = 1'b1;
    step();
    n_vec++; if (jump_start !== 1'b0) begin n_err++; $display("FAIL retrig_jump got %0b exp 0", jump_start); end
    while (sb.size() > 0 && cyc <= 9) begin
      if (sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_vec++;
        if (data_out !== e.val[7:0]) begin
          n_err++; $display("FAIL trig_held_c%0d got %0h exp %0h", cyc, data_out, e.val[7:0]);
        end
      end
      if (sb.size() > 0) step();
    end
    trigger = 1'b0;
    while (data_out !== 8'hFF && cyc < 40) step();
    step(); step();
    n_vec++; if (data_out !== 8'hFF || busy !== 1'b1) begin
      n_err++; $display("FAIL in_hold data %0h busy %0b exp ff 1", data_out, busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++; if (data_out !== 8'h00 || busy !== 1'b0 || rt !== 16'd0 || rt_valid !== 1'b0 || jump_start !== 1'b0) begin
      n_err++; $display("FAIL midhold_reset data %0h busy %0b rt %0d valid %0b jump %0b exp all 0",
                        data_out, busy, rt, rt_valid, jump_start);
    end
    repeat (5) step();
    n_vec++; if (data_out !== 8'h00 || busy !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle data %0h busy %0b exp 0 0", data_out, busy);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    int   lim;
    rst2 = 1'b0;
    n2 = 16'd0;
    trig2 = 1'b1;
    step();
    trig2 = 1'b0;
    n_vec++; if (data2 !== 8'h01) begin n_err++; $display("FAIL sat_start got %0h exp 1", data2); end
    step();
    n_vec++; if (data2 !== 8'h03) begin n_err++; $display("FAIL sat_n0_tick got %0h exp 3", data2); end
    lim = cyc + 300;
    while (!(data2 === 8'h00 && busy2 === 1'b1) && cyc < lim) step();
    n_vec++; if (cyc >= lim) begin n_err++; $display("FAIL sat_reach_go timeout got data %0h exp 0", data2); end
    repeat (40) step();
    n_vec++; if (busy2 !== 1'b1 || rtv2 !== 1'b0) begin
      n_err++; $display("FAIL sat_waiting busy %0b valid %0b exp 1 0", busy2, rtv2);
    end
    btn2 = 1'b1;
    sb.push_back('{cyc: cyc + 1, val: 16'd15});
    step();
    btn2 = 1'b0;
    e = sb.pop_front();
    n_vec++; if (rt2 !== e.val[3:0]) begin n_err++; $display("FAIL sat_rt got %0d exp %0d", rt2, e.val[3:0]); end
    n_vec++; if (rtv2 !== 1'b1) begin n_err++; $display("FAIL sat_valid got %0b exp 1", rtv2); end
    n_vec++; if (js2 !== 1'b0) begin n_err++; $display("FAIL sat_jump got %0b exp 0", js2); end
  endtask

  initial begin
    test_reset();
    test_lights();
    test_hold();
    test_reaction();
    test_jump_start();
    test_trigger_held_and_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
